// File: rtl/rv32_exec_datapath_if.sv
// Execute-datapath bus between the multicycle core FSM (master) and the datapath (slave).
interface rv32_exec_datapath_if #(parameter int XLEN = 32);
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      w;
    logic [XLEN-1:0] data_in;
    logic            we;
    logic [XLEN-1:0] data_out1;
    logic [XLEN-1:0] data_out2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [3:0]      fmt;
    logic [XLEN-1:0] alu_src_a;
    logic [XLEN-1:0] alu_src_b;
    logic [3:0]      alu_ctr;
    logic [XLEN-1:0] alu_resp;

    modport master (
        output rs1, rs2, w, data_in, we, funct3, funct7, fmt, alu_src_a, alu_src_b,
        input  data_out1, data_out2, alu_ctr, alu_resp
    );

    modport slave (
        input  rs1, rs2, w, data_in, we, funct3, funct7, fmt, alu_src_a, alu_src_b,
        output data_out1, data_out2, alu_ctr, alu_resp
    );
endinterface

// File: rtl/rv32_exec_datapath.sv
// RV32I execute datapath: 32x32 register file, ALU-control decoder, registered ALU.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
module rv32_exec_datapath #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32_exec_datapath_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_t;

    localparam logic [3:0] FMT_R = 4'd0;
    localparam logic [3:0] FMT_I = 4'd1;

    logic [XLEN-1:0] regs [32];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_next;
    logic [XLEN-1:0] alu_q;
    logic [4:0]      shamt;
    logic            wr_en;
    logic            unused_funct7;

    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};
    assign wr_en         = bus.we && (bus.w != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            regs[bus.w] <= bus.data_in;
        end
    end

    // x0 is never stored; it is forced to zero on the read side.
    always_comb begin
        rd1 = (bus.rs1 == 5'd0) ? '0 : regs[bus.rs1];
        rd2 = (bus.rs2 == 5'd0) ? '0 : regs[bus.rs2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && (bus.rs1 == bus.w)) rd1 = bus.data_in;
        if (wr_en && (bus.rs2 == bus.w)) rd2 = bus.data_in;
`endif
    end

    assign bus.data_out1 = rd1;
    assign bus.data_out2 = rd2;

    always_comb begin
        alu_op = OP_ADD;
        if ((bus.fmt == FMT_R) || (bus.fmt == FMT_I)) begin
            case (bus.funct3)
                3'b000:  alu_op = ((bus.fmt == FMT_R) && bus.funct7[5]) ? OP_SUB : OP_ADD;
                3'b001:  alu_op = OP_SLL;
                3'b010:  alu_op = OP_SLT;
                3'b011:  alu_op = OP_SLTU;
                3'b100:  alu_op = OP_XOR;
                3'b101:  alu_op = bus.funct7[5] ? OP_SRA : OP_SRL;
                3'b110:  alu_op = OP_OR;
                default: alu_op = OP_AND;
            endcase
        end
    end

    assign bus.alu_ctr = alu_op;
    assign shamt       = bus.alu_src_b[4:0];

    always_comb begin
        alu_next = '0;
        case (alu_op)
            OP_ADD:  alu_next = bus.alu_src_a + bus.alu_src_b;
            OP_SUB:  alu_next = bus.alu_src_a - bus.alu_src_b;
            OP_SLL:  alu_next = bus.alu_src_a << shamt;
            OP_SLT:  alu_next = {{(XLEN-1){1'b0}}, ($signed(bus.alu_src_a) < $signed(bus.alu_src_b))};
            OP_SLTU: alu_next = {{(XLEN-1){1'b0}}, (bus.alu_src_a < bus.alu_src_b)};
            OP_XOR:  alu_next = bus.alu_src_a ^ bus.alu_src_b;
            OP_SRL:  alu_next = bus.alu_src_a >> shamt;
            OP_SRA:  alu_next = $unsigned($signed(bus.alu_src_a) >>> shamt);
            OP_OR:   alu_next = bus.alu_src_a | bus.alu_src_b;
            OP_AND:  alu_next = bus.alu_src_a & bus.alu_src_b;
            default: alu_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_q <= RESET_VAL;
        end else begin
            alu_q <= alu_next;
        end
    end

    assign bus.alu_resp = alu_q;

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// Self-checking bench for rv32_exec_datapath: directed vector table, corner sequences, random vs model.
module tb_rv32_exec_datapath;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [31:0] model_rf [32];

    rv32_exec_datapath_if #(.XLEN(32)) bus ();

    rv32_exec_datapath #(.XLEN(32), .RESET_VAL(32'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_ctr;
        logic [31:0] exp_res;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] wa, input logic [31:0] d);
        bus.we = 1'b1; bus.w = wa; bus.data_in = d;
        tick();
        bus.we = 1'b0;
        if (wa != 5'd0) model_rf[wa] = d;
    endtask

    // Reference semantics of the instruction classes, independent of any op encoding.
    task automatic ref_exec(input logic [3:0] fmt, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic [3:0] ctr, output logic [31:0] res);
        int unsigned sh;
        logic [63:0] ext;
        sh  = int'(b % 32);
        ctr = 4'd0;
        res = a + b;
        if (fmt == 4'd0 || fmt == 4'd1) begin
            case (f3)
                3'd0: if (fmt == 4'd0 && f7[5]) begin ctr = 4'd1; res = a - b; end
                3'd1: begin ctr = 4'd2; res = a * (32'd1 << sh); end
                3'd2: begin ctr = 4'd3; res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
                3'd3: begin ctr = 4'd4; res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0; end
                3'd4: begin ctr = 4'd5; res = a ^ b; end
                3'd5: begin
                    ext = a[31] && f7[5] ? {32'hFFFF_FFFF, a} : {32'd0, a};
                    ext = ext >> sh;
                    ctr = f7[5] ? 4'd7 : 4'd6;
                    res = ext[31:0];
                end
                3'd6: begin ctr = 4'd8; res = a | b; end
                default: begin ctr = 4'd9; res = a & b; end
            endcase
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] ra);
        logic [31:0] v;
        v = (ra == 5'd0) ? 32'd0 : model_rf[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (bus.we && bus.w != 5'd0 && bus.w == ra) v = bus.data_in;
`endif
        return v;
    endfunction

    initial begin
        logic [3:0]  rc;
        logic [31:0] rr;
        logic [31:0] pend;
        vectors = 0;
        miscompares = 0;

        tbl[0]  = '{4'd0,  3'b000, 7'h00, 32'h7FFF_FFFF, 32'h1,         4'd0, 32'h8000_0000};
        tbl[1]  = '{4'd0,  3'b000, 7'h20, 32'h7FFF_FFFF, 32'h1,         4'd1, 32'h7FFF_FFFE};
        tbl[2]  = '{4'd1,  3'b101, 7'h20, 32'h8000_0000, 32'h4,         4'd7, 32'hF800_0000};
        tbl[3]  = '{4'd1,  3'b101, 7'h00, 32'h8000_0000, 32'h4,         4'd6, 32'h0800_0000};
        tbl[4]  = '{4'd0,  3'b010, 7'h00, 32'hFFFF_FFFF, 32'h1,         4'd3, 32'h1};
        tbl[5]  = '{4'd0,  3'b011, 7'h00, 32'hFFFF_FFFF, 32'h1,         4'd4, 32'h0};
        tbl[6]  = '{4'd5,  3'b111, 7'h00, 32'h5,         32'h7,         4'd0, 32'hC};
        tbl[7]  = '{4'd1,  3'b000, 7'h20, 32'h10,        32'h3,         4'd0, 32'h13};
        tbl[8]  = '{4'd0,  3'b001, 7'h00, 32'h1,         32'h21,        4'd2, 32'h2};
        tbl[9]  = '{4'd0,  3'b100, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 32'h0FF0_0FF0};
        tbl[10] = '{4'd0,  3'b110, 7'h00, 32'hF0F0_0000, 32'h0000_0F0F, 4'd8, 32'hF0F0_0F0F};
        tbl[11] = '{4'd1,  3'b111, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9, 32'h00F0_00F0};
        tbl[12] = '{4'd13, 3'b101, 7'h20, 32'hFFFF_FFFF, 32'h2,         4'd0, 32'h1};
        tbl[13] = '{4'd0,  3'b101, 7'h20, 32'h7FFF_FFFF, 32'h1F,        4'd7, 32'h0};

        reset = 1'b1;
        bus.rs1 = '0; bus.rs2 = '0; bus.w = '0; bus.data_in = '0; bus.we = 1'b0;
        bus.funct3 = '0; bus.funct7 = '0; bus.fmt = '0; bus.alu_src_a = '0; bus.alu_src_b = '0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Register file after reset, and x0 immutability.
        chk("reset_alu_resp", bus.alu_resp, 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = 5'(i); bus.rs2 = 5'(31 - i);
            #1;
            chk("reset_rd1", bus.data_out1, 32'd0);
            chk("reset_rd2", bus.data_out2, 32'd0);
        end
        write_reg(5'd0, 32'hDEAD_BEEF);
        bus.rs1 = 5'd0; #1;
        chk("x0_write_ignored", bus.data_out1, 32'd0);

        write_reg(5'd5, 32'h7FFF_FFFF);
        write_reg(5'd6, 32'h1);
        bus.rs1 = 5'd5; bus.rs2 = 5'd6; #1;
        chk("x5_read", bus.data_out1, 32'h7FFF_FFFF);
        chk("x6_read", bus.data_out2, 32'h1);

        for (int i = 0; i < 14; i++) begin
            bus.fmt = tbl[i].fmt; bus.funct3 = tbl[i].f3; bus.funct7 = tbl[i].f7;
            bus.alu_src_a = tbl[i].a; bus.alu_src_b = tbl[i].b;
            #1;
            chk($sformatf("vec%0d_ctr", i), 32'(bus.alu_ctr), 32'(tbl[i].exp_ctr));
            tick();
            chk($sformatf("vec%0d_resp", i), bus.alu_resp, tbl[i].exp_res);
        end

        // Same-cycle read and write of x9.
        write_reg(5'd9, 32'hAAAA_5555);
        bus.we = 1'b1; bus.w = 5'd9; bus.rs1 = 5'd9; bus.data_in = 32'h1234;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("rw_same_cycle", bus.data_out1, 32'h1234);
`else
        chk("rw_same_cycle", bus.data_out1, 32'hAAAA_5555);
`endif
        tick();
        bus.we = 1'b0;
        model_rf[9] = 32'h1234;
        #1;
        chk("rw_next_cycle", bus.data_out1, 32'h1234);

        // Reset beats a concurrent write and discards the pending ALU result.
        write_reg(5'd3, 32'h33);
        bus.fmt = 4'd0; bus.funct3 = 3'b110; bus.funct7 = 7'h00;
        bus.alu_src_a = 32'h1111_0000; bus.alu_src_b = 32'h0000_2222;
        reset = 1'b1; bus.we = 1'b1; bus.w = 5'd3; bus.data_in = 32'h55;
        tick();
        reset = 1'b0; bus.we = 1'b0; bus.rs1 = 5'd3;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        #1;
        chk("reset_drops_write", bus.data_out1, 32'd0);
        chk("reset_alu_resp2", bus.alu_resp, 32'd0);
        tick();
        chk("post_reset_alu", bus.alu_resp, 32'h1111_2222);

        // Random traffic against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            bus.we        = ($urandom_range(0, 1) == 1);
            bus.w         = 5'($urandom_range(0, 31));
            bus.data_in   = $urandom;
            bus.rs1       = ($urandom_range(0, 3) == 0) ? bus.w : 5'($urandom_range(0, 31));
            bus.rs2       = 5'($urandom_range(0, 31));
            bus.fmt       = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) bus.fmt = 4'($urandom_range(0, 1));
            bus.funct3    = 3'($urandom_range(0, 7));
            bus.funct7    = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom_range(0, 127));
            bus.alu_src_a = $urandom;
            bus.alu_src_b = $urandom;
            #1;
            chk("rnd_rd1", bus.data_out1, exp_read(bus.rs1));
            chk("rnd_rd2", bus.data_out2, exp_read(bus.rs2));
            ref_exec(bus.fmt, bus.funct3, bus.funct7, bus.alu_src_a, bus.alu_src_b, rc, rr);
            chk("rnd_ctr", 32'(bus.alu_ctr), 32'(rc));
            pend = rr;
            tick();
            chk("rnd_resp", bus.alu_resp, pend);
            if (bus.we && bus.w != 5'd0) model_rf[bus.w] = bus.data_in;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
